sram_byte_ctrl: RTL and testbench
=================================

# sram_byte_ctrl

Sequenced byte-wide controller for the four-chip asynchronous SRAM array. It sits between the PC/XT system core and the board pins, and replaces the purely combinational address/chip-select decode at the top level. It accepts one byte request at a time over a req/ack handshake and maps the 21-bit byte address onto a 19-bit SRAM address, one of four active-low chip enables, and one of two 8-bit data lanes. It generates timed OE/WE strobes, drives write data with hold time, and returns registered read data.

## Interface
Parameters:
- RD_WAIT, 2: cycles the read strobe stays active (legal range 1..15).
- WR_WAIT, 2: cycles WE_n stays low (legal range 1..15).

Ports:
- clk_100  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  request; level, held by the master until ack.
- we  in  1  1 = write, 0 = read; valid while req is high.
- addr  in  21  byte address; [20:19] selects the chip, [18:0] is the SRAM address.
- wdata  in  8  write byte.
- ack  out  1  one-cycle completion pulse.
- rdata  out  8  read byte; valid from ack onward and held until the next read completes.
- busy  out  1  high whenever the state is not IDLE.
- sram_a  out  19  SRAM address.
- sram_dq_o  out  16  write data, {wdata, wdata}.
- sram_dq_oe  out  2  per-lane output enable: [1] drives [15:8], [0] drives [7:0]. The top level builds the tristates from this.
- sram_dq_i  in  16  SRAM data pins as read back.
- sram_ce_n  out  4  chip enables, active low, one-hot-low when active.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.

## Operation
- Address decode, using the latched address:
  - 00: chip 0, lane [7:0]
  - 01: chip 1, lane [15:8]
  - 10: chip 2, lane [7:0]
  - 11: chip 3, lane [15:8]
  - The lane is selected by addr[19].
- All SRAM-side outputs are registered. There are no combinational paths from req, addr or wdata to the pins.
- FSM states: IDLE, RD, WR, WHOLD.
  - **IDLE:**
    - All strobes are inactive: sram_ce_n=4'hF, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0.
    - sram_a holds its last value.
    - If req=1 and ack=0: latch addr, we and wdata; load the counter; go to RD if we=0, otherwise WR.
  - **RD:**
    - Selected CE_n=0 and sram_oe_n=0 for RD_WAIT cycles.
    - On the last RD cycle, capture the selected lane of sram_dq_i into rdata, pulse ack and return to IDLE. Strobes deassert on that same edge.
  - **WR:**
    - Selected CE_n=0, sram_we_n=0, selected sram_dq_oe bit=1 for WR_WAIT cycles; sram_oe_n stays 1.
    - Then go to WHOLD.
  - **WHOLD (1 cycle):**
    - sram_we_n=1; CE_n, address, data and sram_dq_oe remain active (data hold past the rising edge of WE).
    - At the end of WHOLD, pulse ack and return to IDLE.
- The counter is 4 bits, loaded with WAIT-1 and decremented to 0. There is no wrap.
- A write never modifies rdata.

## Timing
- Reset values: ack=0, rdata=8'h00, busy=0, sram_a=0, sram_dq_o=0, sram_dq_oe=2'b00, sram_ce_n=4'hF, sram_oe_n=1, sram_we_n=1, state=IDLE.
- Accept edge E0: strobes are active in the cycle following E0.
- Read: ack is high in the cycle after edge E0+RD_WAIT. Latency is RD_WAIT+1 cycles from accept to ack.
- Write: sram_we_n is low for exactly WR_WAIT cycles, followed by 1 WHOLD cycle; ack is high in the cycle after WHOLD. Latency is WR_WAIT+2 cycles.
- Handshake:
  - The master drops req at the edge where it samples ack=1.
  - IDLE ignores req while ack=1, so a held request is not re-accepted.
  - A new req may be presented in the cycle after ack; worst-case back-to-back throughput is 1 request per latency+1 cycles.
- Changes to req, addr, we or wdata while busy are ignored; the latched values are used.
- Reset asserted mid-access:
  - All strobes deassert and the lane drive goes off immediately (asynchronously).
  - No ack is produced; rdata is cleared.
  - After release, the FSM is in IDLE and req is evaluated normally.
- CE_n, WE_n and lane enable never glitch between cycles, since all are flop outputs.

## Test plan
- **Reset values:** hold reset_n=0 with req=1 -> all outputs at their reset values, no ack. Release -> accept on the first edge.
- **Read, chip 2:** read addr=21'h100005, sram_dq_i=16'h33C7, RD_WAIT=2 -> sram_a=19'h00005, sram_ce_n=4'b1011, sram_oe_n=0 for 2 cycles; ack on the 3rd cycle with rdata=8'hC7.
- **Write, chip 1:** write addr=21'h080010, wdata=8'hA5, WR_WAIT=2 -> sram_ce_n=4'b1101, sram_dq_oe=2'b10, sram_dq_o[15:8]=8'hA5, we_n low for 2 cycles, then 1 hold cycle with we_n=1 and oe still 2'b10; ack in cycle 4; rdata unchanged.
- **Back-to-back with held req:** read chip 3 addr=21'h180003 (sram_dq_i[15:8]=8'h5A), master keeps req high through ack -> exactly one ack and rdata=8'h5A. A second request issued the cycle after ack is accepted.
- **Reset mid-write:** assert reset_n=0 during the second WR cycle -> sram_we_n=1, sram_ce_n=4'hF, sram_dq_oe=0 immediately; no ack.
- **Minimum waits:** RD_WAIT=1, WR_WAIT=1 -> read ack at cycle 2, write ack at cycle 3, WE_n low for exactly 1 cycle.

Source files
------------

// File: rtl/sram_byte_ctrl.sv
// rtl/sram_byte_ctrl.sv - sequenced byte-wide controller for the four-chip async SRAM array
// One request at a time; every SRAM-side output is a flop so strobes cannot glitch.
module sram_byte_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic        clk_100,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [20:0] addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [18:0] sram_a,
  output logic [15:0] sram_dq_o,
  output logic [1:0]  sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic [3:0]  sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);
  typedef enum logic [1:0] {IDLE, RD, WR, WHOLD} state_t;

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        lane, lane_nx;  // 1 = upper byte lane [15:8]
  logic        ack_nx;
  logic [7:0]  rdata_nx;
  logic [18:0] sram_a_nx;
  logic [15:0] sram_dq_o_nx;
  logic [1:0]  sram_dq_oe_nx;
  logic [3:0]  sram_ce_n_nx;
  logic        sram_oe_n_nx;
  logic        sram_we_n_nx;

  assign busy = (state != IDLE);

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    lane_nx       = lane;
    ack_nx        = 1'b0;
    rdata_nx      = rdata;
    sram_a_nx     = sram_a;
    sram_dq_o_nx  = sram_dq_o;
    sram_dq_oe_nx = sram_dq_oe;
    sram_ce_n_nx  = sram_ce_n;
    sram_oe_n_nx  = sram_oe_n;
    sram_we_n_nx  = sram_we_n;
    case (state)
      IDLE: begin
        sram_ce_n_nx  = 4'hF;
        sram_oe_n_nx  = 1'b1;
        sram_we_n_nx  = 1'b1;
        sram_dq_oe_nx = 2'b00;
        // ack still high means this req is the one just completed
        if (req && !ack) begin
          lane_nx      = addr[19];
          sram_a_nx    = addr[18:0];
          sram_ce_n_nx = ~(4'b0001 << addr[20:19]);
          if (we) begin
            state_nx      = WR;
            cnt_nx        = WR_LOAD;
            sram_we_n_nx  = 1'b0;
            sram_dq_o_nx  = {wdata, wdata};
            sram_dq_oe_nx = addr[19] ? 2'b10 : 2'b01;
          end else begin
            state_nx     = RD;
            cnt_nx       = RD_LOAD;
            sram_oe_n_nx = 1'b0;
          end
        end
      end
      RD: begin
        if (cnt == 4'd0) begin
          rdata_nx     = lane ? sram_dq_i[15:8] : sram_dq_i[7:0];
          ack_nx       = 1'b1;
          state_nx     = IDLE;
          sram_ce_n_nx = 4'hF;
          sram_oe_n_nx = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      WR: begin
        if (cnt == 4'd0) begin
          state_nx     = WHOLD;
          sram_we_n_nx = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      WHOLD: begin
        ack_nx        = 1'b1;
        state_nx      = IDLE;
        sram_ce_n_nx  = 4'hF;
        sram_dq_oe_nx = 2'b00;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lane       <= 1'b0;
      ack        <= 1'b0;
      rdata      <= 8'h00;
      sram_a     <= 19'h0;
      sram_dq_o  <= 16'h0;
      sram_dq_oe <= 2'b00;
      sram_ce_n  <= 4'hF;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      lane       <= lane_nx;
      ack        <= ack_nx;
      rdata      <= rdata_nx;
      sram_a     <= sram_a_nx;
      sram_dq_o  <= sram_dq_o_nx;
      sram_dq_oe <= sram_dq_oe_nx;
      sram_ce_n  <= sram_ce_n_nx;
      sram_oe_n  <= sram_oe_n_nx;
      sram_we_n  <= sram_we_n_nx;
    end
  end
endmodule

// File: tb/tb_sram_byte_ctrl.sv
// tb/tb_sram_byte_ctrl.sv - scoreboard bench for sram_byte_ctrl with a pin-level SRAM array model
module tb_sram_byte_ctrl;
  localparam int RDW = 2;
  localparam int WRW = 2;

  logic clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic        reset_n, req, we, ack, busy, sram_oe_n, sram_we_n;
  logic [20:0] addr;
  logic [7:0]  wdata, rdata;
  logic [18:0] sram_a;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic [1:0]  sram_dq_oe;
  logic [3:0]  sram_ce_n;

  logic        m_req, m_we, m_ack, m_busy, m_oe_n, m_we_n;
  logic [20:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;
  logic [18:0] m_a;
  logic [15:0] m_dq_o;
  logic [15:0] m_dq_i = 16'h9E21;
  logic [1:0]  m_dq_oe;
  logic [3:0]  m_ce_n;

  sram_byte_ctrl #(.RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
    .clk_100(clk_100), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .sram_a(sram_a), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n));

  sram_byte_ctrl #(.RD_WAIT(1), .WR_WAIT(1)) u_min (
    .clk_100(clk_100), .reset_n(reset_n), .req(m_req), .we(m_we), .addr(m_addr), .wdata(m_wdata),
    .ack(m_ack), .rdata(m_rdata), .busy(m_busy), .sram_a(m_a), .sram_dq_o(m_dq_o),
    .sram_dq_oe(m_dq_oe), .sram_dq_i(m_dq_i), .sram_ce_n(m_ce_n),
    .sram_oe_n(m_oe_n), .sram_we_n(m_we_n));

  typedef struct {
    bit          is_wr;
    logic [20:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
    int          issue;
  } txn_t;

  txn_t       sb[$];
  logic [7:0] ref_mem [logic [20:0]];
  logic [7:0] pin_mem [logic [20:0]];
  logic [7:0] ref_last = 8'h00;
  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;

  always @(posedge clk_100) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Background contents of never-written SRAM locations
  function automatic logic [7:0] bg(input logic [20:0] a);
    return a[7:0] ^ {3'b101, a[20:16]};
  endfunction

  function automatic logic [3:0] exp_ce(input logic [20:0] a);
    logic [3:0] c;
    c = 4'b1111;
    c[a[20:19]] = 1'b0;
    return c;
  endfunction

  // Chips 1 and 3 sit on the upper byte lane
  function automatic logic [1:0] exp_lane_oe(input logic [20:0] a);
    return (a[20:19] == 2'd1 || a[20:19] == 2'd3) ? 2'b10 : 2'b01;
  endfunction

  // Four physical chips: store on WE low, drive the chip's lane while OE is low
  always @(negedge clk_100) begin : pin_model
    int nz;
    logic [1:0] ch;
    logic [20:0] k;
    logic [7:0] b;
    nz = 0;
    ch = 2'd0;
    for (int i = 0; i < 4; i++) if (!sram_ce_n[i]) begin nz++; ch = 2'(i); end
    k = {ch, sram_a};
    if (nz == 1 && !sram_we_n) begin
      if (ch[0] && sram_dq_oe[1]) pin_mem[k] = sram_dq_o[15:8];
      else if (!ch[0] && sram_dq_oe[0]) pin_mem[k] = sram_dq_o[7:0];
    end
    b = pin_mem.exists(k) ? pin_mem[k] : bg(k);
    if (nz == 1 && !sram_oe_n) sram_dq_i = ch[0] ? {b, 8'($urandom)} : {8'($urandom), b};
    else sram_dq_i = 16'($urandom);
  end

  always @(negedge clk_100) begin : monitor
    int oe_cnt, we_cnt, hold_cnt;
    bit pins_ok;
    txn_t e;
    if (!reset_n) begin
      oe_cnt = 0; we_cnt = 0; hold_cnt = 0; pins_ok = 1'b1;
    end else begin
      if (sram_ce_n != 4'hF) begin
        if (sb.size() == 0) pins_ok = 1'b0;
        else begin
          e = sb[0];
          if (sram_ce_n != exp_ce(e.addr) || sram_a != e.addr[18:0]) pins_ok = 1'b0;
          if (e.is_wr) begin
            if (sram_oe_n == 1'b0 || sram_dq_oe != exp_lane_oe(e.addr)) pins_ok = 1'b0;
            if (sram_dq_o != {e.wdata, e.wdata}) pins_ok = 1'b0;
          end else if (sram_we_n == 1'b0 || sram_dq_oe != 2'b00) pins_ok = 1'b0;
        end
        if (!sram_oe_n) oe_cnt++;
        if (!sram_we_n) we_cnt++;
        if (sram_oe_n && sram_we_n) hold_cnt++;
      end
      if (ack) begin
        if (sb.size() == 0) check("spurious_ack", ack, 1'b0);
        else begin
          e = sb.pop_front();
          check(e.is_wr ? "wr_latency" : "rd_latency", cyc - e.issue, e.is_wr ? WRW + 2 : RDW + 1);
          check(e.is_wr ? "wr_rdata_kept" : "rd_data", rdata, e.exp_rd);
          check("pins", pins_ok, 1'b1);
          check("busy_at_ack", busy, 1'b0);
          if (e.is_wr) check("we_low_hold", {oe_cnt[7:0], we_cnt[7:0], hold_cnt[7:0]}, {8'd0, 8'(WRW), 8'd1});
          else check("oe_low", {oe_cnt[7:0], we_cnt[7:0], hold_cnt[7:0]}, {8'(RDW), 8'd0, 8'd0});
        end
        oe_cnt = 0; we_cnt = 0; hold_cnt = 0; pins_ok = 1'b1;
      end
    end
  end

  task automatic preload(input logic [20:0] a, input logic [7:0] d);
    pin_mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Called at a negedge; returns at the negedge of the cycle after ack
  task automatic do_req(input bit w, input logic [20:0] a, input logic [7:0] d, input bit hold, input bit rel);
    txn_t t;
    int n;
    req = 1'b1; we = w; addr = a; wdata = d;
    t.is_wr = w; t.addr = a; t.wdata = d; t.issue = cyc;
    if (w) begin
      ref_mem[a] = d;
      t.exp_rd = ref_last;
    end else begin
      t.exp_rd = ref_mem.exists(a) ? ref_mem[a] : bg(a);
      ref_last = t.exp_rd;
    end
    sb.push_back(t);
    if (rel) reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk_100);
      n++;
      if (!ack) begin we = 1'($urandom); addr = 21'($urandom); wdata = 8'($urandom); end
    end while (!ack && n < 40);
    if (!ack) check("ack_timeout", ack, 1'b1);
    if (hold) begin
      we = w; addr = a; wdata = d;
      @(negedge clk_100);
      check("no_reaccept", busy, 1'b0);
    end
    req = 1'b0;
    if (!hold) @(negedge clk_100);
  endtask

  initial begin
    int lat, wl, acks;
    reset_n = 1'b0; req = 1'b1; we = 1'b0; addr = 21'h0A0001; wdata = 8'h00;
    m_req = 1'b0; m_we = 1'b0; m_addr = 21'h0; m_wdata = 8'h00;
    repeat (3) @(negedge clk_100);
    check("rst_ack_busy", {ack, busy}, 2'b00);
    check("rst_rdata", rdata, 8'h00);
    check("rst_a_dq", {sram_a, sram_dq_o}, 35'h0);
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 8'b1111_1_1_00);

    do_req(1'b0, 21'h0A0001, 8'h00, 1'b0, 1'b1);
    preload(21'h100005, 8'hC7);
    preload(21'h180003, 8'h5A);
    do_req(1'b0, 21'h100005, 8'h00, 1'b0, 1'b0);
    do_req(1'b1, 21'h080010, 8'hA5, 1'b0, 1'b0);
    do_req(1'b0, 21'h180003, 8'h00, 1'b1, 1'b0);
    do_req(1'b0, 21'h080010, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom), {2'($urandom), 13'h0, 6'($urandom)}, 8'($urandom),
             $urandom_range(0, 7) == 0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk_100);
    end

    req = 1'b1; we = 1'b1; addr = 21'h1FFFFF; wdata = 8'h3C;
    @(negedge clk_100);
    req = 1'b0;
    @(negedge clk_100);
    check("midwr_we_active", sram_we_n, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midwr_strobes_off", {sram_ce_n, sram_we_n, sram_dq_oe}, 7'b1111_1_00);
    check("midwr_rdata_busy", {rdata, busy}, 9'h000);
    ref_last = 8'h00;
    acks = 0;
    repeat (3) begin @(negedge clk_100); if (ack) acks++; end
    reset_n = 1'b1;
    repeat (2) begin @(negedge clk_100); if (ack) acks++; end
    check("midwr_no_ack", acks, 0);
    do_req(1'b0, 21'h100005, 8'h00, 1'b0, 1'b0);

    m_req = 1'b1; m_we = 1'b0; m_addr = 21'h080123; lat = 0;
    do begin @(negedge clk_100); lat++; end while (!m_ack && lat < 20);
    check("min_rd_latency", lat, 2);
    check("min_rd_data", m_rdata, 8'h9E);
    m_req = 1'b0;
    @(negedge clk_100);
    m_req = 1'b1; m_we = 1'b1; m_addr = 21'h000040; m_wdata = 8'h77; lat = 0; wl = 0;
    do begin @(negedge clk_100); lat++; if (!m_we_n) wl++; end while (!m_ack && lat < 20);
    check("min_wr_latency", lat, 3);
    check("min_we_low", wl, 1);
    check("min_wr_rdata_kept", m_rdata, 8'h9E);
    m_req = 1'b0;
    repeat (2) @(negedge clk_100);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
